// File: rtl/fb_port_arbiter.sv
// Frame-buffer port arbiter: display reads win, camera writes queue in a FIFO.
// Optional FB_ARB_BOUND_CHK_EN adds address bound checks and oob_err.
module fb_port_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 16,
  parameter int FB_DEPTH   = 76800,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                              pclk,
  input  logic                              reset,
  input  logic                              cam_we,
  input  logic [ADDR_W-1:0]                 cam_addr,
  input  logic [DATA_W-1:0]                 cam_data,
  input  logic                              rd_req,
  input  logic [ADDR_W-1:0]                 rd_addr,
  output logic [DATA_W-1:0]                 rd_data,
  output logic                              rd_valid,
  output logic                              mem_en,
  output logic                              mem_we,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic [DATA_W-1:0]                 mem_wdata,
  input  logic [DATA_W-1:0]                 mem_rdata,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
`ifdef FB_ARB_BOUND_CHK_EN
  output logic                              oob_err,
`endif
  output logic                              wr_overflow,
  input  logic                              ovf_clr
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH+1);

  logic [ADDR_W-1:0] q_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] q_data [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  logic empty;
  logic full;
  logic wr_ok;
  logic rd_oob;
  logic rd_mem;
  logic pop;
  logic push_in;
  logic push;
  logic drop;

  logic rd_p1;
  logic rd_p2;
  logic oob_p1;
  logic oob_p2;

`ifdef FB_ARB_BOUND_CHK_EN
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(FB_DEPTH);
  assign wr_ok  = {1'b0, cam_addr} < DEPTH_L;
  assign rd_oob = {1'b0, rd_addr} >= DEPTH_L;
`else
  assign wr_ok  = 1'b1;
  assign rd_oob = 1'b0;
`endif

  assign empty   = fifo_level == '0;
  assign full    = fifo_level == LW'(FIFO_DEPTH);
  assign rd_mem  = rd_req & ~rd_oob;
  assign pop     = ~rd_req & ~empty;
  assign push_in = cam_we & wr_ok;
  // a pop in the same cycle frees the slot a full queue needs
  assign push    = push_in & (~full | pop);
  assign drop    = push_in & full & ~pop;

  always_ff @(posedge pclk) begin
    if (push) begin
      q_addr[wr_ptr] <= cam_addr;
      q_data[wr_ptr] <= cam_data;
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      wr_overflow <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rd_p1       <= 1'b0;
      rd_p2       <= 1'b0;
      oob_p1      <= 1'b0;
      oob_p2      <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
    end else begin
      mem_en <= rd_mem | pop;
      mem_we <= pop;
      if (rd_mem) begin
        mem_addr <= rd_addr;
      end else if (pop) begin
        mem_addr  <= q_addr[rd_ptr];
        mem_wdata <= q_data[rd_ptr];
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
      wr_overflow <= drop | (wr_overflow & ~ovf_clr);
      rd_p1    <= rd_req;
      oob_p1   <= rd_oob;
      rd_p2    <= rd_p1;
      oob_p2   <= oob_p1;
      rd_valid <= rd_p2;
      if (rd_p2) rd_data <= oob_p2 ? '0 : mem_rdata;
    end
  end

`ifdef FB_ARB_BOUND_CHK_EN
  always_ff @(posedge pclk) begin
    if (reset) begin
      oob_err <= 1'b0;
    end else begin
      oob_err <= (cam_we & ~wr_ok) | (rd_req & rd_oob) |
                 (oob_err & ~ovf_clr);
    end
  end
`endif

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Scoreboard bench for fb_port_arbiter: expected RAM writes and read returns
// are queued by the stimulus and retired by a monitor on mem_we / rd_valid.
module tb_fb_port_arbiter;

  logic        pclk = 1'b0;
  logic        reset;
  logic        cam_we;
  logic [16:0] cam_addr;
  logic [15:0] cam_data;
  logic        rd_req;
  logic [16:0] rd_addr;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        mem_en;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic [3:0]  fifo_level;
  logic        wr_overflow;
  logic        ovf_clr;
`ifdef FB_ARB_BOUND_CHK_EN
  logic        oob_err;
`endif

  fb_port_arbiter dut (
    .pclk(pclk), .reset(reset),
    .cam_we(cam_we), .cam_addr(cam_addr), .cam_data(cam_data),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .fifo_level(fifo_level),
`ifdef FB_ARB_BOUND_CHK_EN
    .oob_err(oob_err),
`endif
    .wr_overflow(wr_overflow), .ovf_clr(ovf_clr)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  logic [15:0] ram [int];
  always @(posedge pclk) begin
    if (mem_en) begin
      if (mem_we) ram[int'(mem_addr)] = mem_wdata;
      else mem_rdata <= ram.exists(int'(mem_addr)) ?
                        ram[int'(mem_addr)] : 16'h0;
    end
  end

  typedef struct {
    logic [16:0] a;
    logic [15:0] d;
    int          c;
  } exp_t;

  exp_t wq[$];
  exp_t rq[$];
  int   nvec = 0;
  int   nerr = 0;
  bit   mon_en = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(logic [16:0] a, logic [15:0] d, int c);
    exp_t e;
    e.a = a;
    e.d = d;
    e.c = c;
    return e;
  endfunction

  always @(negedge pclk) begin
    if (mon_en && mem_we) begin
      chk("mem_en_with_we", 32'(mem_en), 32'd1);
      if (wq.size() == 0) begin
        chk("unexpected_write", 32'(mem_addr), 32'h1ffff);
      end else begin
        exp_t e;
        e = wq.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.a));
        chk("wr_data", 32'(mem_wdata), 32'(e.d));
        chk("wr_cycle", 32'(cyc), 32'(e.c));
      end
    end
    if (mon_en && rd_valid) begin
      if (rq.size() == 0) begin
        chk("unexpected_rd_valid", 32'(rd_data), 32'hffffffff);
      end else begin
        exp_t e;
        e = rq.pop_front();
        chk("rd_data", 32'(rd_data), 32'(e.d));
        chk("rd_cycle", 32'(cyc), 32'(e.c));
      end
    end
  end

  task automatic tick();
    @(negedge pclk);
    cam_we  = 1'b0;
    rd_req  = 1'b0;
    ovf_clr = 1'b0;
  endtask

  int m;

  initial begin
`ifdef FB_ARB_BOUND_CHK_EN
    ram[76800] = 16'hDEAD;
`endif
    reset = 1'b1;
    cam_we = 0; cam_addr = '0; cam_data = '0;
    rd_req = 0; rd_addr = '0; ovf_clr = 0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_ovf", 32'(wr_overflow), 0);
    mon_en = 1'b1;

    // single write into an idle queue
    tick();
    cam_we = 1; cam_addr = 17'h00010; cam_data = 16'hABCD;
    wq.push_back(mk(17'h00010, 16'hABCD, cyc + 2));
    tick();
    chk("t1_level_1", 32'(fifo_level), 1);
    tick();
    tick();
    chk("t1_level_0", 32'(fifo_level), 0);

    // 10 back-to-back reads with 3 writes starving behind them
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      rd_req = 1; rd_addr = 17'h10 + 17'(i);
      rq.push_back(mk('0, (i == 0) ? 16'hABCD : 16'h0, cyc + 3));
      if (i == 2 || i == 4 || i == 6) begin
        cam_we = 1;
        cam_addr = 17'h200 + 17'(i);
        cam_data = 16'h1000 + 16'(i);
      end
    end
    m = cyc;
    wq.push_back(mk(17'h202, 16'h1002, m + 2));
    wq.push_back(mk(17'h204, 16'h1004, m + 3));
    wq.push_back(mk(17'h206, 16'h1006, m + 4));
    tick();
    chk("t2_level_3", 32'(fifo_level), 3);
    repeat (6) tick();
    chk("t2_level_0", 32'(fifo_level), 0);

    // overflow: 10 writes into a depth-8 queue while reads hold the port
    for (int i = 0; i < 12; i++) begin
      tick();
      rd_req = 1; rd_addr = 17'h300;
      rq.push_back(mk('0, 16'h0, cyc + 3));
      if (i >= 1 && i <= 10) begin
        cam_we = 1;
        cam_addr = 17'h400 + 17'(i);
        cam_data = 16'h2000 + 16'(i);
      end
    end
    chk("t3_level_8", 32'(fifo_level), 8);
    chk("t3_ovf_set", 32'(wr_overflow), 1);
    tick();
    rd_req = 1; rd_addr = 17'h300; ovf_clr = 1;
    rq.push_back(mk('0, 16'h0, cyc + 3));
    tick();
    rd_req = 1; rd_addr = 17'h300;
    rq.push_back(mk('0, 16'h0, cyc + 3));
    chk("t3_ovf_clr", 32'(wr_overflow), 0);
    m = cyc;
    for (int k = 1; k <= 8; k++)
      wq.push_back(mk(17'h400 + 17'(k), 16'h2000 + 16'(k), m + 1 + k));
    repeat (12) tick();
    chk("t3_drained", 32'(wq.size()), 0);
    chk("t3_level_0", 32'(fifo_level), 0);

    // write-then-read round trip through the RAM
    tick();
    cam_we = 1; cam_addr = 17'd100; cam_data = 16'h1234;
    wq.push_back(mk(17'd100, 16'h1234, cyc + 2));
    repeat (3) tick();
    tick();
    rd_req = 1; rd_addr = 17'd100;
    rq.push_back(mk('0, 16'h1234, cyc + 3));
    repeat (4) tick();

    // reset with 5 queued writes and 2 reads in flight
    for (int i = 0; i < 5; i++) begin
      tick();
      rd_req = 1; rd_addr = 17'h10;
      cam_we = 1;
      cam_addr = 17'h500 + 17'(i);
      cam_data = 16'h3000 + 16'(i);
      if (i < 3) rq.push_back(mk('0, 16'hABCD, cyc + 3));
    end
    tick();
    reset = 1'b1;
    chk("t5_level_5", 32'(fifo_level), 5);
    tick();
    reset = 1'b0;
    chk("t5_level_0", 32'(fifo_level), 0);
    chk("t5_ovf_0", 32'(wr_overflow), 0);
    chk("t5_rd_valid_0", 32'(rd_valid), 0);
    chk("t5_mem_en_0", 32'(mem_en), 0);
    repeat (6) tick();
    chk("t5_rq_empty", 32'(rq.size()), 0);

    // out-of-range address 76800
    tick();
    cam_we = 1; cam_addr = 17'd76800; cam_data = 16'h5555;
`ifdef FB_ARB_BOUND_CHK_EN
    repeat (3) tick();
    chk("t6_oob_err", 32'(oob_err), 1);
    chk("t6_level_0", 32'(fifo_level), 0);
    tick();
    rd_req = 1; rd_addr = 17'd76800;
    rq.push_back(mk('0, 16'h0, cyc + 3));
    repeat (4) tick();
    ovf_clr = 1;
    tick();
    chk("t6_oob_clr", 32'(oob_err), 0);
`else
    wq.push_back(mk(17'd76800, 16'h5555, cyc + 2));
    repeat (3) tick();
    tick();
    rd_req = 1; rd_addr = 17'd76800;
    rq.push_back(mk('0, 16'h5555, cyc + 3));
    repeat (4) tick();
`endif

    repeat (5) tick();
    chk("end_wq_empty", 32'(wq.size()), 0);
    chk("end_rq_empty", 32'(rq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fb_port_arbiter.md
# fb_port_arbiter

Shares the single-port 320x240 RGB565 frame buffer between the camera capture writer and the VGA display reader, all in the `pclk` domain. Display reads always win the RAM port; camera writes are queued in a small FIFO and drained in free cycles such as blanking and unused read slots. A queued write that cannot be stored is dropped and flagged. The block sits between the camera memory controller, the VGA pixel fetch logic and the frame buffer BRAM.

## Interface
- `ADDR_W`, 17, frame-buffer address width.
- `DATA_W`, 16, pixel width (RGB565).
- `FB_DEPTH`, 76800, number of valid pixel addresses (320*240).
- `FIFO_DEPTH`, 8, write-queue entries; power of two, at least 2.
- `pclk`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `cam_we`  in  1  single-cycle write strobe; no backpressure.
- `cam_addr`  in  ADDR_W  write address.
- `cam_data`  in  DATA_W  write pixel.
- `rd_req`  in  1  read request, one per cycle, may be held continuously.
- `rd_addr`  in  ADDR_W  read address.
- `rd_data`  out  DATA_W  read pixel.
- `rd_valid`  out  1  `rd_data` valid, one pulse per accepted `rd_req`.
- `mem_en`  out  1  RAM port enable.
- `mem_we`  out  1  RAM write enable.
- `mem_addr`  out  ADDR_W  RAM address.
- `mem_wdata`  out  DATA_W  RAM write data.
- `mem_rdata`  in  DATA_W  RAM read data; the RAM has a 1-cycle read latency.
- `fifo_level`  out  $clog2(FIFO_DEPTH+1)  number of queued writes.
- `wr_overflow`  out  1  sticky flag: at least one write was dropped.
- `ovf_clr`  in  1  clears `wr_overflow`.

## Operation
- Write queue: each `cam_we` pushes {`cam_addr`, `cam_data`}. The queue is FIFO ordered and never reorders writes.
- Arbitration, evaluated every cycle:
  - `rd_req`=1: issue a read. The queue holds.
  - else if the queue is not empty: pop the head and issue a write.
  - else: idle, `mem_en`=0.
- Reads are never stalled or dropped. Writes may starve while `rd_req` is held.
- A push and a pop in the same cycle are both allowed. The level is unchanged.
- Full queue plus `cam_we`:
  - the new write is dropped and `wr_overflow` is set;
  - if a pop happens in that same cycle, the push is accepted instead and nothing is dropped.
- `wr_overflow` stays set until `ovf_clr`=1. If a drop and `ovf_clr` occur in the same cycle, set wins.
- Read pipeline: a shift register of valid bits aligns `rd_valid` with the captured `mem_rdata`.
- Reset clears the queue pointers, the level, `wr_overflow`, the read pipeline and all `mem_*` outputs. In-flight reads never produce `rd_valid`.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Issue: the arbitration decision made in cycle N drives `mem_en`, `mem_we`, `mem_addr` and `mem_wdata` in cycle N+1.
- Read latency: `rd_req` in cycle N produces `rd_valid`=1 with `rd_data` in cycle N+3, at a sustained rate of one per cycle.
- Write latency: `cam_we` in cycle N into an empty queue, with no `rd_req` in N+1, produces `mem_we`=1 in cycle N+2.
- `fifo_level` updates one cycle after the push or pop edge.
- `mem_we`=1 implies `mem_en`=1.
- `rd_data` holds its last value when `rd_valid`=0.

## Configuration
- `FB_ARB_BOUND_CHK_EN`, when defined:
  - a write with address >= `FB_DEPTH` is discarded at push and never enters the queue;
  - a read with address >= `FB_DEPTH` does not touch the RAM, still returns `rd_valid` at N+3, and returns `rd_data`=0;
  - adds output `oob_err` (1 bit), sticky, cleared by `ovf_clr`.
- Not defined: addresses pass to the RAM unchecked, and `oob_err` does not exist.

## Test plan
- Empty queue, no reads; `cam_we` with addr 0x00010, data 0xABCD -> `mem_we`=1, addr 0x00010, data 0xABCD two cycles later; `fifo_level` returns to 0.
- `rd_req` held for 10 cycles while 3 writes arrive -> all 10 reads issued back to back, `fifo_level`=3; the writes drain in order during the 3 cycles after `rd_req` falls.
- `rd_req` held, 10 writes, `FIFO_DEPTH`=8 -> the first 8 are kept and writes 9 and 10 are dropped; `wr_overflow`=1, level 8; pulse `ovf_clr` -> flag 0; after reads stop, exactly 8 RAM writes occur.
- Write 0x1234 to addr 100, let it drain, then `rd_req` addr 100 -> `rd_valid`=1 with `rd_data`=0x1234 exactly 3 cycles after the request.
- Queue level 5 and two reads in flight, then `reset` for 1 cycle -> level 0, no `rd_valid`, no `mem_we` afterwards; `wr_overflow`=0.
- With `FB_ARB_BOUND_CHK_EN`: write to addr 76800 -> no `mem_we`, `oob_err`=1; read addr 76800 -> `rd_data`=0 at N+3. Without the macro: the same write reaches the RAM at addr 76800.
